param_data_memory: RTL and testbench
====================================

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter DSIZE, default 16, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ASIZE, default 16, address port width in bits.
REQ-003 Parameter DEPTH, default 256, number of words; SHALL be ≤ 2**ASIZE.
REQ-004 Parameter NBYTES, derived as DSIZE/8, number of byte lanes.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ASIZE  word address.
REQ-011 req_wdata  input  DSIZE  write data.
REQ-012 req_be  input  NBYTES  byte-lane write enables; bit i covers bits 8i+7:8i.
REQ-013 rsp_valid  output  1  read data valid, one-cycle pulse per accepted read.
REQ-014 rsp_rdata  output  DSIZE  read data.
REQ-015 rsp_err  output  1  accepted request addressed a word ≥ DEPTH; qualified by rsp_valid for reads, pulses alone for writes.
REQ-016 init_done  output  1  memory clear sweep complete.

Function
REQ-017 FSM states SHALL be INIT (clear sweep) and RUN.
REQ-018 In INIT, a clear pointer SHALL write zero to word 0..DEPTH-1, one word per cycle, req_ready=0; after word DEPTH-1 the FSM SHALL enter RUN on the next edge.
REQ-019 In RUN, req_ready SHALL be 1 and init_done SHALL be 1; a request is accepted when req_valid && req_ready.
REQ-020 Accepted write SHALL update only lanes with req_be[i]=1; req_be=0 SHALL leave the word unchanged.
REQ-021 Accepted read SHALL present rsp_valid=1 and rsp_rdata one cycle after acceptance (latency 1, registered); rsp_rdata SHALL hold its value until the next read response.
REQ-022 rsp_valid SHALL be 0 in any cycle not following an accepted read; writes SHALL NOT raise rsp_valid.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the written data.
REQ-024 Back-to-back reads SHALL be accepted every cycle, sustaining one response per cycle.
REQ-025 Address ≥ DEPTH: write SHALL be discarded; read SHALL return rsp_rdata=0; rsp_err=1 for one cycle in either case.
REQ-026 req_addr bits above log2(DEPTH) SHALL NOT alias onto valid words.
REQ-027 Requests presented while req_ready=0 SHALL be ignored with no side effect.

Reset
REQ-028 rst=0 SHALL immediately force state=INIT, clear pointer=0, req_ready=0, init_done=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-029 Reset during RUN SHALL drop any pending response and restart the full clear sweep after rst returns to 1.
REQ-030 Reset during INIT SHALL restart the sweep at word 0.

Structure
REQ-031 FSM state encodings and default DSIZE/ASIZE SHALL live in the shared define.v include.
REQ-032 Storage SHALL be a sub-module dmem_array (byte-lane-masked synchronous-write, synchronous-read array); control and FSM in param_data_memory.

Verification
REQ-033 Reset release, DEPTH=256 -> req_ready=0 for 256 cycles, then init_done=1; read of 0x0042 -> rsp_rdata=0x0000.
REQ-034 Write 0x0010=0xBEEF be=2'b11, next cycle read 0x0010 -> next cycle rsp_valid=1, rsp_rdata=0xBEEF.
REQ-035 Write 0x0010=0x1234 be=2'b01 over 0xBEEF -> read returns 0xBE34.
REQ-036 Read 0x0100 (DEPTH=256) -> rsp_valid=1, rsp_err=1, rsp_rdata=0; write 0x0100=0xFFFF then read 0x0000 -> 0x0000.
REQ-037 Reads of 0x0001,0x0002,0x0003 on consecutive cycles -> three consecutive rsp_valid pulses, data in order.
REQ-038 Assert rst=0 the cycle after a read is accepted -> rsp_valid stays 0, outputs zero immediately, sweep restarts, prior data reads 0 afterwards.

Source files
------------

// File: rtl/param_data_memory_pkg.sv
// param_data_memory_pkg: shared FSM state type and default geometry for the data memory.
package param_data_memory_pkg;
   typedef enum logic {INIT, RUN} state_e;
   localparam int DSIZE_DEF = 16;
   localparam int ASIZE_DEF = 16;
   localparam int DEPTH_DEF = 256;
endpackage

// File: rtl/param_data_memory_if.sv
// param_data_memory_if: request/response bus of the data memory.
interface param_data_memory_if #(
   parameter int DSIZE = 16,
   parameter int ASIZE = 16
);
   localparam int NBYTES = DSIZE / 8;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ASIZE-1:0]  req_addr;
   logic [DSIZE-1:0]  req_wdata;
   logic [NBYTES-1:0] req_be;
   logic              rsp_valid;
   logic [DSIZE-1:0]  rsp_rdata;
   logic              rsp_err;
   logic              init_done;
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );
endinterface

// File: rtl/param_data_memory_dmem_array.sv
// dmem_array: byte-lane-masked synchronous-write, synchronous-read word array.
module dmem_array #(
   parameter int DSIZE  = 16,
   parameter int DEPTH  = 256,
   parameter int NBYTES = DSIZE / 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [NBYTES-1:0] be_i,
   input  logic [DSIZE-1:0]  wdata_i,
   output logic [DSIZE-1:0]  rdata_o
);
   logic [NBYTES-1:0][7:0] mem [DEPTH];
   logic [DSIZE-1:0]       rdata_q;
   always_ff @(posedge clk)
      if (we_i)
         for (int b = 0; b < NBYTES; b++)
            if (be_i[b]) mem[addr_i][b] <= wdata_i[8*b +: 8];
   // Only the read register is reset; the contents are cleared by the sweep.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata_q <= '0;
      else if (re_i) rdata_q <= mem[addr_i];
   assign rdata_o = rdata_q;
endmodule

// File: rtl/param_data_memory.sv
// param_data_memory: clear-on-reset data memory with byte-lane writes and 1-cycle registered reads.
module param_data_memory
   import param_data_memory_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int ASIZE = ASIZE_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic clk,
   input  logic rst_n,
   param_data_memory_if.slave bus
);
   localparam int NBYTES = DSIZE / 8;
   localparam int AW     = $clog2(DEPTH);
   state_e            state_q, state_d;
   logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
   logic              rsp_valid_q, rsp_err_q, oor_q;
   logic              accept, in_range, arr_we, arr_re;
   logic [AW-1:0]     arr_addr;
   logic [NBYTES-1:0] arr_be;
   logic [DSIZE-1:0]  arr_wdata, arr_rdata;
   // Full-width compare so high address bits never alias onto valid words.
   assign in_range = {1'b0, bus.req_addr} < (ASIZE+1)'(DEPTH);
   assign accept   = bus.req_valid && bus.req_ready;
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      arr_we    = 1'b0;
      arr_re    = 1'b0;
      arr_addr  = bus.req_addr[AW-1:0];
      arr_be    = bus.req_be;
      arr_wdata = bus.req_wdata;
      if (state_q == INIT) begin
         arr_we    = 1'b1;
         arr_addr  = clr_ptr_q;
         arr_be    = '1;
         arr_wdata = '0;
         clr_ptr_d = clr_ptr_q + 1'b1;
         if (clr_ptr_q == AW'(DEPTH - 1)) state_d = RUN;
      end else begin
         arr_we = accept && bus.req_we && in_range;
         arr_re = accept && !bus.req_we && in_range;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= INIT;
         clr_ptr_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         oor_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         rsp_valid_q <= accept && !bus.req_we;
         rsp_err_q   <= accept && !in_range;
         if (accept && !bus.req_we) oor_q <= !in_range;
      end
   dmem_array #(.DSIZE(DSIZE), .DEPTH(DEPTH), .NBYTES(NBYTES), .AW(AW)) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .addr_i  (arr_addr),
      .be_i    (arr_be),
      .wdata_i (arr_wdata),
      .rdata_o (arr_rdata)
   );
   // An out-of-range read returns zero and keeps doing so until the next read.
   assign bus.rsp_rdata = oor_q ? '0 : arr_rdata;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.req_ready = state_q == RUN;
   assign bus.init_done = state_q == RUN;
endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: directed checks of sweep, byte lanes, range errors, streaming reads and reset.
module tb_param_data_memory;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cnt;
   param_data_memory_if #(.DSIZE(16), .ASIZE(16)) bus ();
   param_data_memory #(.DSIZE(16), .ASIZE(16), .DEPTH(256)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = d; bus.req_be = be;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask
   task automatic rd(input logic [15:0] a);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask
   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
      rd(a);
      chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, "_data"}, 32'(bus.rsp_rdata), 32'(exp));
   endtask
   task automatic wait_ready(input string tag);
      cnt = 0;
      while (!bus.req_ready && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      bus.req_valid = 1'b0;
      chk({tag, "_sweep_cycles"}, 32'(cnt), 32'd256);
      chk({tag, "_init_done"}, 32'(bus.init_done), 32'd1);
   endtask
   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_init_done", 32'(bus.init_done), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      rst_n = 1'b1;
      wait_ready("boot");
      rd_chk("rd42", 16'h0042, 16'h0000);
      chk("rd42_err", 32'(bus.rsp_err), 32'd0);
      wr(16'h0010, 16'hBEEF, 2'b11);
      chk("wr_no_valid", 32'(bus.rsp_valid), 32'd0);
      chk("wr_no_err", 32'(bus.rsp_err), 32'd0);
      rd_chk("raw", 16'h0010, 16'hBEEF);
      wr(16'h0010, 16'h1234, 2'b01);
      rd_chk("lane0", 16'h0010, 16'hBE34);
      wr(16'h0010, 16'hAAAA, 2'b10);
      rd_chk("lane1", 16'h0010, 16'hAA34);
      wr(16'h0010, 16'h5555, 2'b00);
      rd_chk("be0", 16'h0010, 16'hAA34);
      @(negedge clk);
      chk("idle_valid", 32'(bus.rsp_valid), 32'd0);
      chk("hold_rdata", 32'(bus.rsp_rdata), 32'h0000AA34);
      rd_chk("oor_rd", 16'h0100, 16'h0000);
      chk("oor_rd_err", 32'(bus.rsp_err), 32'd1);
      @(negedge clk);
      chk("err_pulse", 32'(bus.rsp_err), 32'd0);
      wr(16'h0100, 16'hFFFF, 2'b11);
      chk("oor_wr_err", 32'(bus.rsp_err), 32'd1);
      chk("oor_wr_valid", 32'(bus.rsp_valid), 32'd0);
      rd_chk("oor_wr_w0", 16'h0000, 16'h0000);
      wr(16'h1005, 16'h5A5A, 2'b11);
      chk("alias_err", 32'(bus.rsp_err), 32'd1);
      rd_chk("alias_w5", 16'h0005, 16'h0000);
      wr(16'h0001, 16'h1111, 2'b11);
      wr(16'h0002, 16'h2222, 2'b11);
      wr(16'h0003, 16'h3333, 2'b11);
      rd_chk("b2b1", 16'h0001, 16'h1111);
      rd_chk("b2b2", 16'h0002, 16'h2222);
      rd_chk("b2b3", 16'h0003, 16'h3333);
      @(negedge clk);
      chk("b2b_end", 32'(bus.rsp_valid), 32'd0);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0010;
      @(posedge clk);
      #1 rst_n = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      chk("rrst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rrst_rdata", 32'(bus.rsp_rdata), 32'd0);
      chk("rrst_ready", 32'(bus.req_ready), 32'd0);
      chk("rrst_init_done", 32'(bus.init_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("mid_sweep_ready", 32'(bus.req_ready), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h0005; bus.req_wdata = 16'h7777; bus.req_be = 2'b11;
      wait_ready("resweep");
      rd_chk("post_rst_w10", 16'h0010, 16'h0000);
      rd_chk("post_rst_w1", 16'h0001, 16'h0000);
      rd_chk("ignored_w5", 16'h0005, 16'h0000);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
